// File: rtl/ifu_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// The state encoding, default reset PC and the zero instruction live here.
package ifu_fetch_ctrl_pkg;

   localparam int unsigned XLEN_DEFAULT     = 64;
   localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;
   localparam logic [31:0] INST_ZERO        = 32'h0000_0000;

   typedef enum logic [1:0] {
      StReq  = 2'd0,
      StWait = 2'd1,
      StOut  = 2'd2
   } fetch_state_e;

   // A faulting fetch never forwards whatever the bus put on the data lines.
   function automatic logic [31:0] fault_masked_inst(input logic        err,
                                                     input logic [31:0] data);
      return err ? INST_ZERO : data;
   endfunction

endpackage

// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, keeps one instruction-memory request in
// flight and hands each fetched word plus its PC to decode over valid/ready.
module ifu_fetch_ctrl
   import ifu_fetch_ctrl_pkg::*;
#(
   parameter int unsigned     XLEN     = XLEN_DEFAULT,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
   input  logic            clk,
   input  logic            rst,

   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            imem_rsp_err,

   output logic            out_valid,
   output logic [31:0]     out_inst,
   output logic [XLEN-1:0] out_pc,
   output logic            out_fault,
   input  logic            out_ready,

   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,

   output logic [31:0]     fetch_cnt
);

   fetch_state_e    state_q;
   logic [XLEN-1:0] pc_q;
   logic            drop_q;
   logic [31:0]     inst_q;
   logic [XLEN-1:0] out_pc_q;
   logic            fault_q;
   logic [31:0]     cnt_q;

   logic [XLEN-1:0] redirect_tgt;
   logic            unused_redirect_lsbs;

   assign redirect_tgt         = {redirect_pc[XLEN-1:2], 2'b00};
   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StReq;
         pc_q     <= {RESET_PC[XLEN-1:2], 2'b00};
         drop_q   <= 1'b0;
         inst_q   <= INST_ZERO;
         out_pc_q <= RESET_PC;
         fault_q  <= 1'b0;
         cnt_q    <= 32'd0;
      end else begin
         unique case (state_q)
            StReq: begin
               // A redirect racing the accept lets the old request go out but marks its
               // response for discard; without the accept only the address moves.
               if (imem_req_ready) begin
                  state_q <= StWait;
                  drop_q  <= redirect_valid;
               end
               if (redirect_valid) begin
                  pc_q <= redirect_tgt;
               end
            end

            StWait: begin
               if (imem_rsp_valid) begin
                  drop_q <= 1'b0;
                  if (drop_q || redirect_valid) begin
                     state_q <= StReq;
                  end else begin
                     inst_q   <= fault_masked_inst(imem_rsp_err, imem_rsp_data);
                     fault_q  <= imem_rsp_err;
                     out_pc_q <= pc_q;
                     state_q  <= StOut;
                  end
               end else if (redirect_valid) begin
                  drop_q <= 1'b1;
               end
               if (redirect_valid) begin
                  pc_q <= redirect_tgt;
               end
            end

            StOut: begin
               if (out_ready) begin
                  cnt_q <= cnt_q + 32'd1;
               end
               if (redirect_valid) begin
                  pc_q    <= redirect_tgt;
                  state_q <= StReq;
               end else if (out_ready) begin
                  pc_q    <= pc_q + XLEN'(4);
                  state_q <= StReq;
               end
            end

            default: begin
               state_q <= StReq;
            end
         endcase
      end
   end

   // The request is held low while reset is applied even though the state is already StReq.
   assign imem_req_valid = (state_q == StReq) && !rst;
   assign imem_req_addr  = pc_q;

   assign out_valid = (state_q == StOut);
   assign out_inst  = inst_q;
   assign out_pc    = out_pc_q;
   assign out_fault = fault_q;
   assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Bench for ifu_fetch_ctrl: a cycle table of directed scenarios, then a randomised
// memory/decode environment checked against a stream-level model of the fetch PC.
module tb_ifu_fetch_ctrl;
   import ifu_fetch_ctrl_pkg::*;

   localparam logic [63:0] A0 = 64'h8000_0000;

   logic        clk;
   logic        rst;
   logic        imem_req_valid;
   logic [63:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        imem_rsp_err;
   logic        out_valid;
   logic [31:0] out_inst;
   logic [63:0] out_pc;
   logic        out_fault;
   logic        out_ready;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic [31:0] fetch_cnt;

   ifu_fetch_ctrl #(
      .XLEN     (64),
      .RESET_PC (A0)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .imem_rsp_err   (imem_rsp_err),
      .out_valid      (out_valid),
      .out_inst       (out_inst),
      .out_pc         (out_pc),
      .out_fault      (out_fault),
      .out_ready      (out_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fetch_cnt      (fetch_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        rdy;
      logic        rspv;
      logic [31:0] data;
      logic        err;
      logic        ordy;
      logic        redir;
      logic [63:0] rpc;
      logic        e_rv;
      logic [63:0] e_addr;
      logic        e_ov;
      logic [31:0] e_inst;
      logic [63:0] e_pc;
      logic        e_fault;
      logic [31:0] e_cnt;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rdy, input logic rspv, input logic [31:0] data,
                      input logic err, input logic ordy, input logic redir,
                      input logic [63:0] rpc, input logic e_rv, input logic [63:0] e_addr,
                      input logic e_ov, input logic [31:0] e_inst, input logic [63:0] e_pc,
                      input logic e_fault, input logic [31:0] e_cnt);
      vec_t v;
      v.rdy = rdy;   v.rspv = rspv; v.data = data;     v.err = err;
      v.ordy = ordy; v.redir = redir; v.rpc = rpc;
      v.e_rv = e_rv; v.e_addr = e_addr; v.e_ov = e_ov; v.e_inst = e_inst;
      v.e_pc = e_pc; v.e_fault = e_fault; v.e_cnt = e_cnt;
      vecs.push_back(v);
   endtask

   // Memory image used by the random phase: data and fault both derived from the address.
   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return (a[31:0] * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic mem_err(input logic [63:0] a);
      return a[6:2] == 5'h0B;
   endfunction

   task automatic drive_idle();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      imem_rsp_err   = 1'b0;
      out_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 64'h0;
   endtask

   logic [63:0] exp_pc;
   logic [31:0] m_cnt;
   logic [63:0] busy_addr;
   logic [63:0] prev_addr;
   logic [31:0] exp_inst;
   bit          busy;
   bit          prev_pend;
   bit          prev_redir;
   int          lat;
   int          delivered;

   initial begin
      rst = 1'b1;
      drive_idle();

      // Zero-wait stream, stalls, drops, coincident redirects and a fault, cycle by cycle.
      add(1,0,0,0,0,0,0,                1,A0,         0,0,0,0,            0);
      add(0,1,32'h13,0,0,0,0,           0,0,          0,0,0,0,            0);
      add(0,0,0,0,1,0,0,                0,0,          1,32'h13,A0,0,      0);
      add(1,0,0,0,0,0,0,                1,A0+64'h4,   0,0,0,0,            1);
      add(0,1,32'h13,0,0,0,0,           0,0,          0,0,0,0,            1);
      add(0,0,0,0,1,0,0,                0,0,          1,32'h13,A0+64'h4,0, 1);
      add(1,0,0,0,0,0,0,                1,A0+64'h8,   0,0,0,0,            2);
      add(0,1,32'h13,0,0,0,0,           0,0,          0,0,0,0,            2);
      add(0,0,0,0,1,0,0,                0,0,          1,32'h13,A0+64'h8,0, 2);
      for (int k = 0; k < 4; k++)
         add(0,0,0,0,0,0,0,             1,A0+64'hC,   0,0,0,0,            3);
      add(1,0,0,0,0,0,0,                1,A0+64'hC,   0,0,0,0,            3);
      add(0,1,32'hAAAA_0001,0,0,0,0,    0,0,          0,0,0,0,            3);
      for (int k = 0; k < 5; k++)
         add(0,0,0,0,0,0,0,             0,0,          1,32'hAAAA_0001,A0+64'hC,0, 3);
      add(0,0,0,0,1,0,0,                0,0,          1,32'hAAAA_0001,A0+64'hC,0, 3);
      add(1,0,0,0,0,0,0,                1,A0+64'h10,  0,0,0,0,            4);
      add(0,0,0,0,0,1,A0+64'h103,       0,0,          0,0,0,0,            4);
      add(0,0,0,0,0,0,0,                0,0,          0,0,0,0,            4);
      add(0,1,32'hDEAD_BEEF,0,0,0,0,    0,0,          0,0,0,0,            4);
      add(1,0,0,0,0,0,0,                1,A0+64'h100, 0,0,0,0,            4);
      add(0,1,32'h0000_1234,0,0,0,0,    0,0,          0,0,0,0,            4);
      add(0,0,0,0,1,1,A0+64'h1000,      0,0,          1,32'h1234,A0+64'h100,0, 4);
      add(1,0,0,0,0,0,0,                1,A0+64'h1000, 0,0,0,0,           5);
      add(0,1,32'hFFFF_FFFF,1,0,0,0,    0,0,          0,0,0,0,            5);
      add(0,0,0,0,1,0,0,                0,0,          1,32'h0,A0+64'h1000,1, 5);
      add(0,0,0,0,0,1,A0+64'h2002,      1,A0+64'h1004, 0,0,0,0,           6);
      add(1,0,0,0,0,0,0,                1,A0+64'h2000, 0,0,0,0,           6);
      add(0,1,32'h55,0,0,0,0,           0,0,          0,0,0,0,            6);
      add(0,0,0,0,1,0,0,                0,0,          1,32'h55,A0+64'h2000,0, 6);
      add(1,0,0,0,0,1,A0+64'h3000,      1,A0+64'h2004, 0,0,0,0,           7);
      add(0,1,32'h77,0,0,0,0,           0,0,          0,0,0,0,            7);
      add(0,0,0,0,0,0,0,                1,A0+64'h3000, 0,0,0,0,           7);

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_inst",  out_inst, 0);
      chk("rst_out_pc",    out_pc, A0);
      chk("rst_out_fault", out_fault, 0);
      chk("rst_fetch_cnt", fetch_cnt, 0);
      chk("rst_req_addr",  imem_req_addr, A0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         imem_req_ready = vecs[i].rdy;
         imem_rsp_valid = vecs[i].rspv;
         imem_rsp_data  = vecs[i].data;
         imem_rsp_err   = vecs[i].err;
         out_ready      = vecs[i].ordy;
         redirect_valid = vecs[i].redir;
         redirect_pc    = vecs[i].rpc;
         #1;
         chk($sformatf("vec%0d_req_valid", i), imem_req_valid, vecs[i].e_rv);
         if (vecs[i].e_rv)
            chk($sformatf("vec%0d_req_addr", i), imem_req_addr, vecs[i].e_addr);
         chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_ov);
         if (vecs[i].e_ov) begin
            chk($sformatf("vec%0d_out_inst", i), out_inst, vecs[i].e_inst);
            chk($sformatf("vec%0d_out_pc", i), out_pc, vecs[i].e_pc);
            chk($sformatf("vec%0d_out_fault", i), out_fault, vecs[i].e_fault);
         end
         chk($sformatf("vec%0d_fetch_cnt", i), fetch_cnt, vecs[i].e_cnt);
         @(negedge clk);
      end
      drive_idle();

      // Reset in the middle of a run clears the counter and reloads the PC.
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("midrst_req_valid", imem_req_valid, 0);
      chk("midrst_fetch_cnt", fetch_cnt, 0);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_req_addr",  imem_req_addr, A0);
      rst = 1'b0;

      exp_pc     = A0;
      m_cnt      = 0;
      busy       = 0;
      lat        = 0;
      prev_pend  = 0;
      prev_redir = 0;
      busy_addr  = 0;
      prev_addr  = 0;
      delivered  = 0;

      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         chk("rand_fetch_cnt", fetch_cnt, m_cnt);
         if (prev_pend && !prev_redir) begin
            chk("rand_req_hold_valid", imem_req_valid, 1);
            chk("rand_req_hold_addr", imem_req_addr, prev_addr);
         end
         if (imem_req_valid && busy) begin
            n_bad++;
            $display("FAIL rand_one_outstanding: req_valid=1 with a response pending");
         end

         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
         imem_rsp_err   = 1'($urandom_range(0, 1));
         if (busy) begin
            if (lat == 0) begin
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = mem_word(busy_addr);
               imem_rsp_err   = mem_err(busy_addr);
               busy           = 0;
            end else begin
               lat--;
            end
         end

         imem_req_ready = ($urandom_range(0, 2) != 0);
         if (imem_req_valid && imem_req_ready) begin
            chk("rand_req_align", {62'd0, imem_req_addr[1:0]}, 0);
            busy      = 1;
            lat       = $urandom_range(0, 3);
            busy_addr = imem_req_addr;
         end

         out_ready      = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 11) == 0);
         redirect_pc    = A0 + 64'($urandom_range(0, 4095));

         // Delivered stream: each handshake is the next sequential PC unless redirected.
         if (out_valid && out_ready) begin
            exp_inst = mem_err(exp_pc) ? 32'h0 : mem_word(exp_pc);
            chk("rand_out_pc", out_pc, exp_pc);
            chk("rand_out_inst", out_inst, exp_inst);
            chk("rand_out_fault", out_fault, mem_err(exp_pc));
            m_cnt  = m_cnt + 1;
            exp_pc = exp_pc + 64'd4;
            delivered++;
         end
         if (redirect_valid)
            exp_pc = redirect_pc & ~64'h3;

         prev_pend  = imem_req_valid && !imem_req_ready;
         prev_addr  = imem_req_addr;
         prev_redir = redirect_valid;
      end

      chk("rand_progress", (delivered > 100) ? 64'd1 : 64'd0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
